// File: rtl/cmat_mul_seq.sv
// cmat_mul_seq: sequenced complex matrix product C = A x B for N x N matrices.
// A and B stream in row-major on a valid/ready port. One shared complex MAC
// walks i, j, k (k innermost) over N^3 cycles, and C streams out row-major.
// Optional build macro CMAT_MUL_SAT_EN: when defined, each 20-bit accumulator
// saturates to 16 bits on its write to C. When undefined, the low 16 bits are
// kept, so the value wraps.
module cmat_mul_seq #(
    parameter int N = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  in_real,
    input  logic signed [7:0]  in_imag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_real,
    output logic signed [15:0] out_imag,
    output logic               out_last,
    output logic               busy
);

    localparam int NN = N * N;
    localparam int IW = $clog2(N);
    localparam int EW = $clog2(NN);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [EW-1:0] ELEM_LAST = EW'(NN - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_OUT
    } state_t;

    state_t state, state_next;

    // Matrix storage keeps its contents through reset; every run reloads it.
    logic signed [7:0]  a_re [NN];
    logic signed [7:0]  a_im [NN];
    logic signed [7:0]  b_re [NN];
    logic signed [7:0]  b_im [NN];
    logic signed [15:0] c_re [NN];
    logic signed [15:0] c_im [NN];

    logic [EW-1:0] ld_idx;
    logic          ld_b;
    logic [IW-1:0] i_idx, j_idx, k_idx;
    logic [EW-1:0] out_idx;

    logic signed [19:0] acc_re, acc_im;
    logic signed [19:0] acc_re_next, acc_im_next;

    logic [EW-1:0] a_addr, b_addr, c_addr;
    logic signed [7:0]  ar, ai, br, bi;
    logic signed [15:0] pp_rr, pp_ii, pp_ri, pp_ir;
    logic signed [16:0] prod_re, prod_im;

    logic in_fire, out_fire, load_done, mac_done;

    // Narrow a 20-bit sum to the 16-bit C element.
    function automatic logic signed [15:0] narrow(input logic signed [19:0] v);
`ifdef CMAT_MUL_SAT_EN
        if (v > 20'sd32767) begin
            return 16'sh7fff;
        end else if (v < -20'sd32768) begin
            return 16'sh8000;
        end else begin
            return 16'(v);
        end
`else
        return 16'(v);
`endif
    endfunction

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign load_done = in_fire && ld_b && (ld_idx == ELEM_LAST);
    assign mac_done  = (i_idx == IDX_LAST) && (j_idx == IDX_LAST) && (k_idx == IDX_LAST);

    // Next-state logic and the per-state handshake and status outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (load_done) begin
                    state_next = S_MAC;
                end
            end
            S_MAC: begin
                busy = 1'b1;
                if (mac_done) begin
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_fire && (out_idx == ELEM_LAST)) begin
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_LOAD;
        endcase
    end

    // Output element mux. Outputs read zero outside OUT, so stale C never leaks out.
    always_comb begin
        out_real = '0;
        out_imag = '0;
        out_last = 1'b0;
        if (state == S_OUT) begin
            out_real = c_re[out_idx];
            out_imag = c_im[out_idx];
            out_last = (out_idx == ELEM_LAST);
        end
    end

    // State register. A reset in any state drops back to LOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Load, MAC and output counters. Each one wraps to zero at the end of its phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_idx  <= '0;
            ld_b    <= 1'b0;
            i_idx   <= '0;
            j_idx   <= '0;
            k_idx   <= '0;
            out_idx <= '0;
        end else begin
            if (in_fire) begin
                if (ld_idx == ELEM_LAST) begin
                    ld_idx <= '0;
                    ld_b   <= ~ld_b;
                end else begin
                    ld_idx <= ld_idx + EW'(1);
                end
            end
            if (state == S_MAC) begin
                if (k_idx == IDX_LAST) begin
                    k_idx <= '0;
                    if (j_idx == IDX_LAST) begin
                        j_idx <= '0;
                        i_idx <= (i_idx == IDX_LAST) ? '0 : i_idx + IW'(1);
                    end else begin
                        j_idx <= j_idx + IW'(1);
                    end
                end else begin
                    k_idx <= k_idx + IW'(1);
                end
            end
            if (out_fire) begin
                out_idx <= (out_idx == ELEM_LAST) ? '0 : out_idx + EW'(1);
            end
        end
    end

    // Complex MAC datapath. Products are exact, and the running sum restarts at k = 0.
    always_comb begin
        a_addr = EW'(int'(i_idx) * N + int'(k_idx));
        b_addr = EW'(int'(k_idx) * N + int'(j_idx));
        c_addr = EW'(int'(i_idx) * N + int'(j_idx));
        ar = a_re[a_addr];
        ai = a_im[a_addr];
        br = b_re[b_addr];
        bi = b_im[b_addr];
        pp_rr = 16'(ar) * 16'(br);
        pp_ii = 16'(ai) * 16'(bi);
        pp_ri = 16'(ar) * 16'(bi);
        pp_ir = 16'(ai) * 16'(br);
        prod_re = 17'(pp_rr) - 17'(pp_ii);
        prod_im = 17'(pp_ri) + 17'(pp_ir);
        acc_re_next = ((k_idx == '0) ? 20'sd0 : acc_re) + 20'(prod_re);
        acc_im_next = ((k_idx == '0) ? 20'sd0 : acc_im) + 20'(prod_im);
    end

    // Operand capture, accumulator update and C write-back. None of this is reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (!ld_b) begin
                a_re[ld_idx] <= in_real;
                a_im[ld_idx] <= in_imag;
            end else begin
                b_re[ld_idx] <= in_real;
                b_im[ld_idx] <= in_imag;
            end
        end
        if (state == S_MAC) begin
            acc_re <= acc_re_next;
            acc_im <= acc_im_next;
            if (k_idx == IDX_LAST) begin
                c_re[c_addr] <= narrow(acc_re_next);
                c_im[c_addr] <= narrow(acc_im_next);
            end
        end
    end

endmodule

// File: tb/tb_cmat_mul_seq.sv
// tb_cmat_mul_seq: scoreboard bench for cmat_mul_seq at N = 4.
// The 2x2 directed cases sit in the top-left corner of otherwise-zero 4x4
// matrices. The saturation case follows CMAT_MUL_SAT_EN.
module tb_cmat_mul_seq;

    localparam int N  = 4;
    localparam int NN = N * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [7:0] in_real = '0;
    logic signed [7:0] in_imag = '0;
    logic in_ready, out_valid, out_last, busy;
    logic signed [15:0] out_real, out_imag;

    cmat_mul_seq #(.N(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_real(in_real),
        .in_imag(in_imag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_real(out_real),
        .out_imag(out_imag),
        .out_last(out_last),
        .busy(busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int pass_cnt = 0;
    int total_cnt = 0;
    int cur_ar[NN], cur_ai[NN], cur_br[NN], cur_bi[NN];
    int exp_re[NN], exp_im[NN];
    bit stall_prev = 1'b0;
    int held_re = 0;
    int held_im = 0;

    function automatic void checkOutput(string name, int actual, int expected);
        total_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endfunction

    function automatic void reportTimeout(string name);
        total_cnt++;
        $display("[TB] FAIL %s: timed out waiting on the DUT", name);
    endfunction

    // Monitor: checks stall stability, then pops and compares every output transfer.
    always @(negedge clk) begin
        if (stall_prev) begin
            checkOutput("stall out_valid", int'(out_valid), 1);
            checkOutput("stall out_real", int'(out_real), held_re);
            checkOutput("stall out_imag", int'(out_imag), held_im);
        end
        if (out_valid && !out_ready) begin
            stall_prev = 1'b1;
            held_re = int'(out_real);
            held_im = int'(out_imag);
        end else begin
            stall_prev = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected output: got %0d/%0d, expected none", out_real, out_imag);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("out_real", int'(out_real), mon_e.re);
                checkOutput("out_imag", int'(out_imag), mon_e.im);
                checkOutput("out_last", int'(out_last), mon_e.last ? 1 : 0);
            end
        end
    end

    task automatic clearTables();
        for (int e = 0; e < NN; e++) begin
            cur_ar[e] = 0; cur_ai[e] = 0; cur_br[e] = 0; cur_bi[e] = 0;
            exp_re[e] = 0; exp_im[e] = 0;
        end
    endtask

    // A = [[1+2i, 3], [0, -1i]], B = [[2, 1i], [1-1i, 4]], both in the top-left corner.
    task automatic setTest1();
        clearTables();
        cur_ar[0] = 1;  cur_ai[0] = 2;
        cur_ar[1] = 3;
        cur_ai[5] = -1;
        cur_br[0] = 2;
        cur_bi[1] = 1;
        cur_br[4] = 1;  cur_bi[4] = -1;
        cur_br[5] = 4;
        exp_re[0] = 5;  exp_im[0] = 1;
        exp_re[1] = 10; exp_im[1] = 1;
        exp_re[4] = -1; exp_im[4] = -1;
        exp_re[5] = 0;  exp_im[5] = -4;
    endtask

    // A = identity, so C reproduces B exactly, including the -128 and 127 extremes.
    task automatic setTest2();
        int br_t[NN] = '{7, -128, 0, -5, 0, 1, 50, 0, -7, 100, -128, 127, 2, 0, 64, -3};
        int bi_t[NN] = '{-3, 0, 9, 8, 127, 1, -50, 0, 12, 3, -128, 127, -2, -1, -64, 9};
        clearTables();
        for (int e = 0; e < NN; e++) begin
            cur_br[e] = br_t[e];
            cur_bi[e] = bi_t[e];
            exp_re[e] = br_t[e];
            exp_im[e] = bi_t[e];
        end
        for (int d = 0; d < N; d++) begin
            cur_ar[d * N + d] = 1;
        end
    endtask

    // Every element is -128-128i: real sums to 0, imag sums to 131072.
    task automatic setTest3();
        for (int e = 0; e < NN; e++) begin
            cur_ar[e] = -128; cur_ai[e] = -128; cur_br[e] = -128; cur_bi[e] = -128;
            exp_re[e] = 0;
`ifdef CMAT_MUL_SAT_EN
            exp_im[e] = 32767;
`else
            exp_im[e] = 0;
`endif
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        for (int n = 0; n < NN; n++) begin
            e.re = exp_re[n];
            e.im = exp_im[n];
            e.last = (n == NN - 1);
            exp_q.push_back(e);
        end
    endtask

    // Streams A then B, one beat per accepted handshake. Called #1 after an edge.
    task automatic applyStimulus();
        int cyc;
        for (int b = 0; b < 2 * NN; b++) begin
            in_valid = 1'b1;
            in_real = (b < NN) ? 8'(cur_ar[b]) : 8'(cur_br[b - NN]);
            in_imag = (b < NN) ? 8'(cur_ai[b]) : 8'(cur_bi[b - NN]);
            cyc = 0;
            while (!in_ready && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            if (cyc >= 100) begin
                reportTimeout("in_ready");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("busy after load", int'(busy), 1);
        checkOutput("in_ready after load", int'(in_ready), 0);
    endtask

    // Waits for the queue to drain and LOAD to return. Can keep in_valid high with junk data.
    task automatic waitDone(input bit keep_valid);
        int cyc = 0;
        in_valid = keep_valid;
        while ((exp_q.size() != 0 || !in_ready) && cyc < 2000) begin
            if (keep_valid) begin
                in_real = 8'($urandom);
                in_imag = 8'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 2000) begin
            reportTimeout("result drain");
            exp_q.delete();
        end
    endtask

    // Directed sequence: reset, three products, backpressure, mid-MAC reset, reload.
    initial begin
        int cyc;
        $display("[TB] start");
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", int'(in_ready), 1);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset out_last", int'(out_last), 0);
        checkOutput("reset out_real", int'(out_real), 0);
        checkOutput("reset out_imag", int'(out_imag), 0);
        rst_n = 1'b1;

        setTest1();
        pushExpected();
        applyStimulus();
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 200) begin
            reportTimeout("first out_valid");
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDone(1'b0);

        setTest2();
        pushExpected();
        applyStimulus();
        waitDone(1'b1);

        setTest3();
        pushExpected();
        applyStimulus();
        waitDone(1'b0);

        setTest2();
        applyStimulus();
        repeat (20) @(posedge clk);
        #1;
        checkOutput("busy mid MAC", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("abort in_ready", int'(in_ready), 1);
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort out_valid", int'(out_valid), 0);
        checkOutput("abort out_real", int'(out_real), 0);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("idle after abort", int'(out_valid), 0);

        setTest1();
        pushExpected();
        applyStimulus();
        waitDone(1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cmat_mul_seq.md
# cmat_mul_seq

Sequencer that computes the complex matrix product C = A × B for N×N matrices of 8-bit signed complex elements, using one shared complex multiply-accumulate datapath over N³ cycles. Operands arrive on a valid/ready input stream, and results leave on a valid/ready output stream. It sits above the combinational complex multiplier and turns the single-element product into a full matrix operation for the matrix-multiplication subsystem.

## Interface
Parameters:
- N, 2, matrix dimension; legal values 2..4.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  an input element is present.
- in_ready  output  1  block accepts an input element this cycle.
- in_real  input  8  signed real part of the input element.
- in_imag  input  8  signed imaginary part of the input element.
- out_valid  output  1  a result element is present.
- out_ready  input  1  the consumer accepts the result element.
- out_real  output  16  signed real part of C[i][j].
- out_imag  output  16  signed imaginary part of C[i][j].
- out_last  output  1  high with the final element C[N-1][N-1].
- busy  output  1  high in the MAC and OUT states.

## Operation
- States and transitions:
  - LOAD: in_ready=1. Accepts 2·N² beats on in_valid&&in_ready. The first N² beats are A, row-major; the next N² beats are B, row-major. The last accepted beat moves the block to MAC.
  - MAC: one step per cycle. Indices i, j, k nest with k innermost, then j, then i. Each step computes acc += A[i][k]·B[k][j] as a complex product:
    - real part = ar·br − ai·bi
    - imag part = ar·bi + ai·br
  - MAC accumulator handling:
    - acc is cleared when k=0.
    - When k=N-1, the final sum is written to C[i][j].
    - After N³ steps, the block moves to OUT.
  - OUT: out_valid=1. The block presents C row-major and advances on out_valid&&out_ready. After the last element is transferred, it returns to LOAD.
- Arithmetic:
  - Products are computed at full precision: 16-bit per partial product, 17-bit after the add/sub.
  - The accumulators are 20-bit signed (real and imag separately). They are exact for N≤4.
  - The narrowing of the 20-bit accumulators to the 16-bit outputs is set by SAT_EN (see Configuration).
- in_valid is ignored outside LOAD. out_ready is ignored outside OUT.
- The A, B and C storage is internal registers. Storage is not cleared by reset; only state and counters are.

## Timing
- Reset is synchronous: any clock edge with rst_n=0 forces state=LOAD and clears all counters. Output values after that edge:
  - in_ready=1
  - out_valid=0
  - out_last=0
  - busy=0
  - out_real=0 and out_imag=0
- Reset mid-operation (MAC or OUT) aborts the computation. No partial results are emitted.
- Latency: if the last input beat is accepted on edge t, MAC occupies edges t+1..t+N³, and out_valid is high from the cycle after edge t+N³.
- Each OUT element holds stable while out_valid=1 and out_ready=0.
- Input and output phases never overlap. Throughput is one matrix per 2N² + N³ + N² cycles, with no backpressure.
- When out_ready is held high, the output elements transfer on consecutive cycles. in_ready rises in the cycle after the last output transfer.

## Configuration
- CMAT_MUL_SAT_EN:
  - Defined: each 20-bit accumulator is saturated to [-32768, 32767] on write to C.
  - Undefined: the low 16 bits are taken, giving two's-complement wrap.

## Test plan
- N=2. A = [[1+2i, 3], [0, -1i]], B = [[2, 1i], [1-1i, 4]] → outputs in order: 5+1i, 10+1i, -1-1i, 0-4i. out_last is high only on the 4th output.
- N=2. A = identity, B = [[7-3i, -128], [127i, 1+1i]] → C = B, exactly.
- N=4. Every element of A and B is -128-128i → every C element has real = 0 and imag = 131072.
  - With CMAT_MUL_SAT_EN: out_imag = 32767.
  - Without it: out_imag = 0.
- Backpressure: hold out_ready=0 for 3 cycles during the 2nd output → out_real/out_imag stay constant and out_valid stays high. No element is dropped or duplicated.
- Assert rst_n=0 for one edge midway through MAC → next cycle in_ready=1, busy=0, out_valid=0. A fresh load then produces correct results.
- Hold in_valid=1 continuously with changing data through MAC and OUT → the extra beats are not consumed. The results match only the 2N² beats accepted in LOAD.
